// File: rtl/imm_gen_pkg.sv
// ---------------------------------------------------------------------------
// imm_gen_pkg
// Shared definitions for the registered immediate generator.
//   fmt_e      : format tag carried alongside each decoded immediate
//   OPC_*      : base-ISA major opcodes (inst[6:0]) recognised by the decoder
//   is_32bit_encoding : true when inst[1:0] marks a full 32-bit encoding
//
// The handshake entry {imm, fmt, illegal, inst, pc} is declared inside
// imm_gen_pipe as entry_t, because its imm/pc fields are XLEN wide and a
// package typedef cannot follow a module parameter.
// ---------------------------------------------------------------------------
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // Compressed (16-bit) encodings use inst[1:0] != 2'b11; this block
    // only understands full-width words and flags everything else.
    function automatic logic is_32bit_encoding(input logic [31:0] inst);
        return inst[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/imm_decode.sv
// ---------------------------------------------------------------------------
// imm_decode
// Purely combinational opcode classifier and immediate extractor.
// Ports:
//   inst    in  32    instruction word
//   imm     out XLEN  immediate, sign-extended from inst[31]
//   fmt     out 3     format tag (fmt_e)
//   illegal out 1     opcode not recognised or not a 32-bit encoding
// ---------------------------------------------------------------------------
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    // Every immediate is first assembled as a 32-bit value whose bit 31 is
    // already the sign; widening to XLEN is then a single signed cast.
    logic [31:0] raw;

    // Classify the opcode and scatter/gather the immediate bits for the
    // matching format. Unknown opcodes fall through to FMT_NONE, imm 0.
    always_comb begin
        raw     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b1;
        if (is_32bit_encoding(inst)) begin
            case (inst[6:0])
                OPC_LUI, OPC_AUIPC: begin
                    raw     = {inst[31:12], 12'b0};
                    fmt     = FMT_U;
                    illegal = 1'b0;
                end
                OPC_JAL: begin
                    raw     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                               inst[30:21], 1'b0};
                    fmt     = FMT_J;
                    illegal = 1'b0;
                end
                OPC_BRANCH: begin
                    raw     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                               inst[11:8], 1'b0};
                    fmt     = FMT_B;
                    illegal = 1'b0;
                end
                OPC_STORE: begin
                    raw     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                    fmt     = FMT_S;
                    illegal = 1'b0;
                end
                OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: begin
                    raw     = {{20{inst[31]}}, inst[31:20]};
                    fmt     = FMT_I;
                    illegal = 1'b0;
                end
                OPC_OP: begin
                    fmt     = FMT_R;
                    illegal = 1'b0;
                end
                OPC_OP_IMM_32: begin
                    if (XLEN == 64) begin
                        raw     = {{20{inst[31]}}, inst[31:20]};
                        fmt     = FMT_I;
                        illegal = 1'b0;
                    end
                end
                OPC_OP_32: begin
                    if (XLEN == 64) begin
                        fmt     = FMT_R;
                        illegal = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
// Registered immediate generator for the decode stage with valid/ready
// handshaking, optional two-entry skid buffer, flush and illegal flagging.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   flush                synchronous discard of all held entries
//   in_valid/in_ready    input handshake
//   in_inst, in_pc       instruction word and PC (PC passed through)
//   out_valid/out_ready  output handshake
//   out_imm, out_fmt     decoded immediate and format tag
//   out_illegal          unrecognised opcode or non-32-bit encoding
//   out_inst, out_pc     instruction and PC passed through
// Parameters:
//   XLEN  32 or 64
//   SKID  1 = main + skid registers, in_ready registered
//         0 = single register, in_ready combinational
// ---------------------------------------------------------------------------
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0,
                                       inst: '0, pc: '0};

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    entry_t          dec_entry;
    entry_t          main_q;
    logic            main_valid;
    logic            accept;
    logic            drain;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    // Bundle the freshly decoded instruction into one entry for loading.
    always_comb begin
        dec_entry         = ENTRY_RESET;
        dec_entry.imm     = dec_imm;
        dec_entry.fmt     = dec_fmt;
        dec_entry.illegal = dec_illegal;
        dec_entry.inst    = in_inst;
        dec_entry.pc      = in_pc;
    end

    assign accept = in_valid && in_ready;
    assign drain  = main_valid && out_ready;

    generate
        if (SKID) begin : g_skid
            entry_t skid_q;
            logic   skid_valid;

            // in_ready depends only on a flop, so upstream sees no
            // combinational path from out_ready.
            assign in_ready = !skid_valid;

            // Main register always holds the oldest entry. When it drains
            // (or is empty) it refills from skid first, else from the input;
            // an accept while main is stalled parks the entry in skid.
            // Data registers are left untouched on flush: only valids clear.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                    main_q     <= ENTRY_RESET;
                    skid_q     <= ENTRY_RESET;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end else if (!main_valid || drain) begin
                    if (skid_valid) begin
                        main_q     <= skid_q;
                        main_valid <= 1'b1;
                        skid_valid <= 1'b0;
                    end else if (accept) begin
                        main_q     <= dec_entry;
                        main_valid <= 1'b1;
                    end else begin
                        main_valid <= 1'b0;
                    end
                end else if (accept) begin
                    skid_q     <= dec_entry;
                    skid_valid <= 1'b1;
                end
            end
        end else begin : g_single
            assign in_ready = !main_valid || out_ready;

            // Single stage: load on accept (which covers drain-and-refill),
            // otherwise empty out once the consumer takes the entry.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                    main_q     <= ENTRY_RESET;
                end else if (flush) begin
                    main_valid <= 1'b0;
                end else if (accept) begin
                    main_q     <= dec_entry;
                    main_valid <= 1'b1;
                end else if (drain) begin
                    main_valid <= 1'b0;
                end
            end
        end
    endgenerate

    assign out_valid   = main_valid;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_inst    = main_q.inst;
    assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
// Drives two instances from the same stimulus: dut_a (XLEN=32, SKID=1) and
// dut_b (XLEN=64, SKID=0). A queue-based reference model per instance
// predicts in_ready, out_valid and the head-of-line output every cycle.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm, a_out_inst, a_out_pc;
    logic [2:0]  a_out_fmt;

    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm, b_out_pc;
    logic [31:0] b_out_inst;
    logic [2:0]  b_out_fmt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .SKID(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_pc(in_pc[31:0]),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal),
        .out_inst(a_out_inst), .out_pc(a_out_pc)
    );

    imm_gen_pipe #(.XLEN(64), .SKID(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal),
        .out_inst(b_out_inst), .out_pc(b_out_pc)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        illegal;
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
    } vec_t;

    exp_t        qa[$];
    exp_t        qb[$];
    vec_t        vecs[13];
    logic [31:0] skid_inst[3];
    logic [31:0] got[$];
    logic [6:0]  ops[13];

    // Reference decode straight from the ISA rules: each immediate is the
    // signed field value times its implicit scale.
    function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc,
                                   input bit is64);
        exp_t   e;
        longint v;
        v         = 0;
        e.inst    = inst;
        e.pc      = is64 ? pc : {32'b0, pc[31:0]};
        e.fmt     = 3'd7;
        e.illegal = 1'b1;
        if (inst[1:0] == 2'b11) begin
            case (inst[6:0])
                7'b0110111, 7'b0010111: begin
                    v = longint'($signed(inst[31:12])) * 4096;
                    e.fmt = 3'd4; e.illegal = 1'b0;
                end
                7'b1101111: begin
                    v = longint'($signed({inst[31], inst[19:12], inst[20], inst[30:21]})) * 2;
                    e.fmt = 3'd5; e.illegal = 1'b0;
                end
                7'b1100011: begin
                    v = longint'($signed({inst[31], inst[7], inst[30:25], inst[11:8]})) * 2;
                    e.fmt = 3'd3; e.illegal = 1'b0;
                end
                7'b0100011: begin
                    v = longint'($signed({inst[31:25], inst[11:7]}));
                    e.fmt = 3'd2; e.illegal = 1'b0;
                end
                7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
                    v = longint'($signed(inst[31:20]));
                    e.fmt = 3'd1; e.illegal = 1'b0;
                end
                7'b0110011: begin
                    e.fmt = 3'd0; e.illegal = 1'b0;
                end
                7'b0011011: if (is64) begin
                    v = longint'($signed(inst[31:20]));
                    e.fmt = 3'd1; e.illegal = 1'b0;
                end
                7'b0111011: if (is64) begin
                    e.fmt = 3'd0; e.illegal = 1'b0;
                end
                default: begin
                end
            endcase
        end
        e.imm = v;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [199:0] act,
                               input logic [199:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] inst,
                                 input logic [63:0] pc, input logic ordy,
                                 input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Cycle monitor: compare against the model queues, then advance the
    // model by what the coming edge will do.
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            checkOutput("a_reset", 200'({a_out_valid, a_in_ready, a_out_imm, a_out_fmt,
                                         a_out_illegal, a_out_inst, a_out_pc}),
                        200'({1'b0, 1'b1, 32'b0, 3'd7, 1'b0, 32'b0, 32'b0}));
            checkOutput("b_reset", 200'({b_out_valid, b_in_ready, b_out_imm, b_out_fmt,
                                         b_out_illegal, b_out_inst, b_out_pc}),
                        200'({1'b0, 1'b1, 64'b0, 3'd7, 1'b0, 32'b0, 64'b0}));
        end else begin
            checkOutput("a_valid", 200'(a_out_valid), 200'(qa.size() > 0));
            checkOutput("a_ready", 200'(a_in_ready), 200'(qa.size() < 2));
            checkOutput("b_valid", 200'(b_out_valid), 200'(qb.size() > 0));
            checkOutput("b_ready", 200'(b_in_ready), 200'(qb.size() == 0 || out_ready));
            if (a_out_valid && qa.size() > 0)
                checkOutput("a_data", 200'({a_out_imm, a_out_fmt, a_out_illegal, a_out_inst, a_out_pc}),
                            200'({qa[0].imm[31:0], qa[0].fmt, qa[0].illegal, qa[0].inst, qa[0].pc[31:0]}));
            if (b_out_valid && qb.size() > 0)
                checkOutput("b_data", 200'({b_out_imm, b_out_fmt, b_out_illegal, b_out_inst, b_out_pc}),
                            200'({qb[0].imm, qb[0].fmt, qb[0].illegal, qb[0].inst, qb[0].pc}));
            if (flush) begin
                qa.delete();
                qb.delete();
            end else begin
                logic ra, rb;
                ra = qa.size() < 2;
                rb = qb.size() == 0 || out_ready;
                if (qa.size() > 0 && out_ready) void'(qa.pop_front());
                if (qb.size() > 0 && out_ready) void'(qb.pop_front());
                if (in_valid && ra) qa.push_back(model(in_inst, in_pc, 1'b0));
                if (in_valid && rb) qb.push_back(model(in_inst, in_pc, 1'b1));
            end
        end
    end

    initial begin
        int          k;
        logic [63:0] pc;
        logic [31:0] r;
        logic [6:0]  op;
        int          idx;

        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, FMT_I,    1'b0, 64'hFFFFFFFFFFFFFFFF, FMT_I,    1'b0};
        vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, FMT_B,    1'b0, 64'hFFFFFFFFFFFFFFFC, FMT_B,    1'b0};
        vecs[2]  = '{32'h12345037, 32'h12345000, FMT_U,    1'b0, 64'h0000000012345000, FMT_U,    1'b0};
        vecs[3]  = '{32'h0080006F, 32'h00000008, FMT_J,    1'b0, 64'h0000000000000008, FMT_J,    1'b0};
        vecs[4]  = '{32'h800000B7, 32'h80000000, FMT_U,    1'b0, 64'hFFFFFFFF80000000, FMT_U,    1'b0};
        vecs[5]  = '{32'hFE112E23, 32'hFFFFFFFC, FMT_S,    1'b0, 64'hFFFFFFFFFFFFFFFC, FMT_S,    1'b0};
        vecs[6]  = '{32'h00000000, 32'h00000000, FMT_NONE, 1'b1, 64'h0,                FMT_NONE, 1'b1};
        vecs[7]  = '{32'h0000007F, 32'h00000000, FMT_NONE, 1'b1, 64'h0,                FMT_NONE, 1'b1};
        vecs[8]  = '{32'h00B50533, 32'h00000000, FMT_R,    1'b0, 64'h0,                FMT_R,    1'b0};
        vecs[9]  = '{32'hFFF0009B, 32'h00000000, FMT_NONE, 1'b1, 64'hFFFFFFFFFFFFFFFF, FMT_I,    1'b0};
        vecs[10] = '{32'h0000003B, 32'h00000000, FMT_NONE, 1'b1, 64'h0,                FMT_R,    1'b0};
        vecs[11] = '{32'h7FF00013, 32'h000007FF, FMT_I,    1'b0, 64'h00000000000007FF, FMT_I,    1'b0};
        vecs[12] = '{32'hFFDFF06F, 32'hFFFFFFFC, FMT_J,    1'b0, 64'hFFFFFFFFFFFFFFFC, FMT_J,    1'b0};

        skid_inst[0] = 32'h00100093;
        skid_inst[1] = 32'h00200113;
        skid_inst[2] = 32'h00300193;

        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100011, 7'b0100011,
                7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011,
                7'b0110011, 7'b0011011, 7'b0111011};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = '0; in_pc = '0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;

        // Table vectors, one at a time with the consumer always ready.
        for (int i = 0; i < 13; i++) begin
            pc = 64'h8000_0000_0000_1000 + 64'(i * 4);
            applyStimulus(1'b1, vecs[i].inst, pc, 1'b1, 1'b0);
            applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_a", i),
                        200'({a_out_valid, a_out_imm, a_out_fmt, a_out_illegal, a_out_inst, a_out_pc}),
                        200'({1'b1, vecs[i].imm32, vecs[i].fmt32, vecs[i].ill32, vecs[i].inst, pc[31:0]}));
            checkOutput($sformatf("vec%0d_b", i),
                        200'({b_out_valid, b_out_imm, b_out_fmt, b_out_illegal, b_out_inst, b_out_pc}),
                        200'({1'b1, vecs[i].imm64, vecs[i].fmt64, vecs[i].ill64, vecs[i].inst, pc}));
        end

        // Back-to-back: beq -4, lui, jal +8 on consecutive cycles.
        applyStimulus(1'b1, 32'hFE000EE3, 64'h100, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h12345037, 64'h104, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("b2b_0", 200'({a_out_valid, a_out_imm, a_out_fmt}), 200'({1'b1, 32'hFFFFFFFC, 3'd3}));
        applyStimulus(1'b1, 32'h0080006F, 64'h108, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("b2b_1", 200'({a_out_valid, a_out_imm, a_out_fmt}), 200'({1'b1, 32'h12345000, 3'd4}));
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("b2b_2", 200'({a_out_valid, a_out_imm, a_out_fmt}), 200'({1'b1, 32'h00000008, 3'd5}));
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Skid: consumer stalled, three offered, two taken.
        k = 0;
        for (int c = 0; c < 6 && k < 2; c++) begin
            applyStimulus(1'b1, skid_inst[k], 64'h2000 + 64'(k * 4), 1'b0, 1'b0);
            @(negedge clk);
            if (a_in_ready) k++;
        end
        checkOutput("skid_accepts", 200'(k), 200'(2));
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, skid_inst[2], 64'h2008, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("skid_full_ready", 200'(a_in_ready), 200'(1'b0));
            checkOutput("skid_hold", 200'({a_out_valid, a_out_inst, a_out_imm, a_out_pc}),
                        200'({1'b1, skid_inst[0], 32'h1, 32'h2000}));
        end
        got.delete();
        k = 2;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(k < 3, skid_inst[2], 64'h2008, 1'b1, 1'b0);
            @(negedge clk);
            if (in_valid && a_in_ready) k++;
            if (a_out_valid) got.push_back(a_out_inst);
        end
        checkOutput("skid_count", 200'(got.size()), 200'(3));
        for (int i = 0; i < 3; i++)
            if (i < got.size()) checkOutput($sformatf("skid_order%0d", i), 200'(got[i]), 200'(skid_inst[i]));

        // Flush with two entries held and a valid input offered.
        applyStimulus(1'b1, skid_inst[0], 64'h3000, 1'b0, 1'b0);
        applyStimulus(1'b1, skid_inst[1], 64'h3004, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0FF00093, 64'h3008, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("flush2_a", 200'({a_out_valid, a_in_ready}), 200'({1'b0, 1'b1}));
        checkOutput("flush2_b", 200'({b_out_valid, b_in_ready}), 200'({1'b0, 1'b1}));

        // Flush with one held and an input that is actually accepted.
        applyStimulus(1'b1, skid_inst[0], 64'h4000, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0FF00093, 64'h4004, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("flush1_gone", 200'({a_out_valid, b_out_valid, a_in_ready}),
                        200'({1'b0, 1'b0, 1'b1}));
        end

        // Reset pulsed while two entries are stalled.
        applyStimulus(1'b1, skid_inst[0], 64'h5000, 1'b0, 1'b0);
        applyStimulus(1'b1, skid_inst[1], 64'h5004, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_a", 200'({a_out_valid, a_in_ready, a_out_fmt, a_out_inst}),
                    200'({1'b0, 1'b1, 3'd7, 32'h0}));
        @(posedge clk); #1 rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            r   = $urandom();
            idx = $urandom_range(0, 15);
            op  = (idx < 13) ? ops[idx] : 7'($urandom());
            applyStimulus($urandom_range(0, 9) < 7, {r[31:7], op}, {$urandom(), $urandom()},
                          $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
        end
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
